// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  localparam int unsigned DefNcores   = 2;
  localparam int unsigned DefMemWords = 256;

  // Width of a core index; at least one bit so single-core builds stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_picker
  import dmem_pkg::*;
#(
  parameter int unsigned NCORES = DefNcores,
  localparam int unsigned PW    = idx_width(NCORES)
) (
  input  logic [NCORES-1:0] req,
  input  logic [PW-1:0]     rr_ptr,
  output logic              valid,
  output logic [PW-1:0]     grant
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset back to rr_ptr so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NCORES);
      if (req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter of NCORES M-stage ports onto one synchronous-read word memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned NCORES    = DefNcores,
  parameter int unsigned MEM_WORDS = DefMemWords,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCORES-1:0]      req,
  input  logic [NCORES-1:0]      we,
  input  logic [NCORES*32-1:0]   addr,
  input  logic [NCORES*32-1:0]   wdata,
  output logic [NCORES*32-1:0]   rdata,
  output logic [NCORES-1:0]      stall
);

  localparam int unsigned PW = idx_width(NCORES);

  state_e                   st_q;
  logic [PW-1:0]            rr_ptr_q;
  logic [PW-1:0]            gnt_q;
  logic [NCORES-1:0][31:0]  rdata_q;
  logic [NCORES-1:0][31:0]  rdata_mux;
  logic [31:0]              rd_q;
  logic [31:0]              mem [MEM_WORDS];

  logic [NCORES-1:0][31:0]  addr_a;
  logic [NCORES-1:0][31:0]  wdata_a;
  logic                     pick_valid;
  logic [PW-1:0]            pick;
  logic [AW-1:0]            sel_word;
  logic                     do_store;
  logic                     do_load;
  logic                     unused_addr;

  assign addr_a  = addr;
  assign wdata_a = wdata;

  rr_picker #(
    .NCORES(NCORES)
  ) u_picker (
    .req   (req),
    .rr_ptr(rr_ptr_q),
    .valid (pick_valid),
    .grant (pick)
  );

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] g);
    if (int'(g) == NCORES - 1) return '0;
    return g + PW'(1);
  endfunction

  assign sel_word = addr_a[pick][AW+1:2];
  assign do_store = (st_q == StIdle) && pick_valid && we[pick];
  assign do_load  = (st_q == StIdle) && pick_valid && !we[pick];

  // Byte offset and bits above the word index are don't-care: addresses wrap.
  always_comb begin
    unused_addr = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      unused_addr = unused_addr ^ (^{addr_a[i][31:AW+2], addr_a[i][1:0]});
    end
  end

  // Single port: at most one store or one read issue per cycle, never in StRead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_store) mem[sel_word] <= wdata_a[pick];
      if (do_load)  rd_q <= mem[sel_word];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= StIdle;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      case (st_q)
        StIdle: begin
          if (pick_valid) begin
            if (we[pick]) begin
              rr_ptr_q <= next_idx(pick);
            end else begin
              gnt_q <= pick;
              st_q  <= StRead;
            end
          end
        end
        StRead: begin
          rdata_q[gnt_q] <= rd_q;
          rr_ptr_q       <= next_idx(gnt_q);
          st_q           <= StIdle;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  // Completing grantee is released and sees its load data in the same cycle.
  always_comb begin
    stall     = req;
    rdata_mux = rdata_q;
    if (st_q == StRead) begin
      stall[gnt_q]     = 1'b0;
      rdata_mux[gnt_q] = rd_q;
    end else if (do_store) begin
      stall[pick] = 1'b0;
    end
  end

  assign rdata = rdata_mux;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cycle table, reset abort, random vs model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic [1:0]  stall;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .NCORES   (2),
    .MEM_WORDS(256),
    .AW       (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .stall(stall)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [1:0]  stall;
    logic [1:0]  chk;
    logic [31:0] r0;
    logic [31:0] r1;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam logic [31:0] A = 32'hA5A5A5A5;
  localparam logic [31:0] W = 32'h12345678;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] wen,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic [31:0] d1);
    rst   = r;
    req   = rq;
    we    = wen;
    addr  = {a1, a0};
    wdata = {d1, d0};
  endtask

  task automatic add(input logic [1:0] rq, input logic [1:0] wen,
                     input logic [31:0] a0, input logic [31:0] d0,
                     input logic [31:0] a1, input logic [31:0] d1,
                     input logic [1:0] st, input logic [1:0] ck,
                     input logic [31:0] r0, input logic [31:0] r1);
    vecs.push_back('{req: rq, we: wen, a0: a0, d0: d0, a1: a1, d1: d1,
                     stall: st, chk: ck, r0: r0, r1: r1});
  endtask

  // One cycle: inputs already driven; compare at negedge, then advance past posedge.
  task automatic cycle_check(input string tag, input logic [1:0] est, input logic [1:0] ck,
                             input logic [31:0] r0, input logic [31:0] r1);
    @(negedge clk);
    check({tag, " stall"}, {30'd0, stall}, {30'd0, est});
    if (ck[0]) check({tag, " rdata0"}, rdata[31:0], r0);
    if (ck[1]) check({tag, " rdata1"}, rdata[63:32], r1);
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Reference model state for the random phase.
  logic [31:0] mmem [256];
  bit          mknown [256];
  logic [31:0] mrd [2];
  bit          mrk [2];
  int          ptr;
  int          busy;
  int          bword;
  int          g;
  bit          preq [2];
  bit          pwe [2];
  logic [31:0] pa [2];
  logic [31:0] pd [2];
  bit          held [2];
  logic [1:0]  exp_st;

  initial begin
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then store/load on core 0.
    add(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0);
    add(2'b01, 2'b01, 32'h10, D, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b01, 2'b00, 32'h10, 0, 0, 0, 2'b01, 2'b11, 0, 0);
    add(2'b01, 2'b00, 32'h10, 0, 0, 0, 2'b00, 2'b01, D, 0);
    add(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, D, 0);
    // Cross-core: core 1 stores, core 0 loads; rdata1 untouched.
    add(2'b10, 2'b10, 0, 0, 32'h20, A, 2'b00, 2'b00, 0, 0);
    add(2'b01, 2'b00, 32'h20, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    add(2'b01, 2'b00, 32'h20, 0, 0, 0, 2'b00, 2'b11, A, 0);
    add(2'b10, 2'b10, 0, 0, 32'h24, 32'h11111111, 2'b00, 2'b00, 0, 0);
    // Contention with rr_ptr=0: core 0 first, then core 1.
    add(2'b11, 2'b00, 32'h10, 0, 32'h20, 0, 2'b11, 2'b00, 0, 0);
    add(2'b11, 2'b00, 32'h10, 0, 32'h20, 0, 2'b10, 2'b01, D, 0);
    add(2'b11, 2'b00, 32'h10, 0, 32'h20, 0, 2'b11, 2'b00, 0, 0);
    add(2'b11, 2'b00, 32'h10, 0, 32'h20, 0, 2'b01, 2'b11, D, A);
    add(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, D, A);
    // Wrap-around and byte-offset alignment.
    add(2'b01, 2'b01, 32'h403, W, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b01, 2'b00, 32'h000, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    add(2'b01, 2'b00, 32'h000, 0, 0, 0, 2'b00, 2'b11, W, A);
    add(2'b10, 2'b10, 0, 0, 32'h40, 0, 2'b00, 2'b00, 0, 0);
    // Back-to-back stores: grants alternate 0,1,0,1...
    add(2'b11, 2'b11, 32'h100, 32'hC0000000, 32'h140, 32'hC1000000, 2'b10, 2'b00, 0, 0);
    add(2'b11, 2'b11, 32'h104, 32'hC0000001, 32'h140, 32'hC1000000, 2'b01, 2'b00, 0, 0);
    add(2'b11, 2'b11, 32'h104, 32'hC0000001, 32'h144, 32'hC1000001, 2'b10, 2'b00, 0, 0);
    add(2'b11, 2'b11, 32'h108, 32'hC0000002, 32'h144, 32'hC1000001, 2'b01, 2'b00, 0, 0);
    add(2'b11, 2'b11, 32'h108, 32'hC0000002, 32'h148, 32'hC1000002, 2'b10, 2'b00, 0, 0);
    add(2'b11, 2'b11, 32'h10C, 32'hC0000003, 32'h148, 32'hC1000002, 2'b01, 2'b00, 0, 0);
    add(2'b11, 2'b11, 32'h10C, 32'hC0000003, 32'h14C, 32'hC1000003, 2'b10, 2'b00, 0, 0);
    add(2'b10, 2'b10, 0, 0, 32'h14C, 32'hC1000003, 2'b00, 2'b00, 0, 0);
    // Read back a sample of those stores.
    add(2'b01, 2'b00, 32'h100, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    add(2'b01, 2'b00, 32'h100, 0, 0, 0, 2'b00, 2'b01, 32'hC0000000, 0);
    add(2'b10, 2'b00, 0, 0, 32'h14C, 0, 2'b10, 2'b00, 0, 0);
    add(2'b10, 2'b00, 0, 0, 32'h14C, 0, 2'b00, 2'b10, 0, 32'hC1000003);
    add(2'b01, 2'b00, 32'h104, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    add(2'b01, 2'b00, 32'h104, 0, 0, 0, 2'b00, 2'b01, 32'hC0000001, 0);
    add(2'b10, 2'b00, 0, 0, 32'h148, 0, 2'b10, 2'b00, 0, 0);
    add(2'b10, 2'b00, 0, 0, 32'h148, 0, 2'b00, 2'b10, 0, 32'hC1000002);

    foreach (vecs[n]) begin
      drive(1'b0, vecs[n].req, vecs[n].we, vecs[n].a0, vecs[n].d0, vecs[n].a1, vecs[n].d1);
      cycle_check($sformatf("row%0d", n), vecs[n].stall, vecs[n].chk, vecs[n].r0, vecs[n].r1);
    end

    // Reset mid-READ: leave rr_ptr=1, start a core 1 load, reset in its READ cycle.
    drive(1'b0, 2'b01, 2'b01, 32'hC0, 32'h0BADF00D, 0, 0);
    cycle_check("rst_pre_store", 2'b00, 2'b00, 0, 0);
    drive(1'b0, 2'b10, 2'b00, 0, 0, 32'h20, 0);
    cycle_check("rst_pre_load", 2'b10, 2'b00, 0, 0);
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    drive(1'b0, 2'b00, 2'b00, 0, 0, 0, 0);
    cycle_check("rst_after", 2'b00, 2'b11, 0, 0);
    drive(1'b0, 2'b11, 2'b00, 32'h10, 0, 32'h24, 0);
    cycle_check("rst_g0", 2'b11, 2'b11, 0, 0);
    cycle_check("rst_d0", 2'b10, 2'b11, D, 0);
    cycle_check("rst_g1", 2'b11, 2'b11, D, 0);
    cycle_check("rst_d1", 2'b01, 2'b11, D, 32'h11111111);

    // Random phase against the model, starting from a fresh reset.
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    ptr  = 0;
    busy = -1;
    for (int i = 0; i < 2; i++) begin
      mrd[i]  = '0;
      mrk[i]  = 1'b1;
      held[i] = 1'b0;
    end
    for (int i = 0; i < 256; i++) mknown[i] = 1'b0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!held[i]) begin
          preq[i] = ($urandom_range(0, 3) != 0);
          pwe[i]  = ($urandom_range(0, 1) == 1);
          pa[i]   = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 7)) << 2)
                    | 32'($urandom_range(0, 3));
          pd[i]   = $urandom;
        end
      end
      drive(1'b0, {preq[1], preq[0]}, {pwe[1], pwe[0]}, pa[0], pd[0], pa[1], pd[1]);

      exp_st = {preq[1], preq[0]};
      if (busy >= 0) begin
        exp_st[busy] = 1'b0;
        mrd[busy]    = mmem[bword];
        mrk[busy]    = mknown[bword];
        ptr          = (busy + 1) % 2;
        busy         = -1;
      end else begin
        g = -1;
        for (int k = 0; k < 2; k++) begin
          if (g < 0 && preq[(ptr + k) % 2]) g = (ptr + k) % 2;
        end
        if (g >= 0) begin
          if (pwe[g]) begin
            exp_st[g]           = 1'b0;
            mmem[widx(pa[g])]   = pd[g];
            mknown[widx(pa[g])] = 1'b1;
            ptr                 = (g + 1) % 2;
          end else begin
            busy  = g;
            bword = widx(pa[g]);
          end
        end
      end
      held[0] = exp_st[0];
      held[1] = exp_st[1];
      cycle_check($sformatf("rand%0d", cyc), exp_st, {mrk[1], mrk[0]}, mrd[0], mrd[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
